// File: rtl/traffic_light_ctrl_pkg.sv
// Shared state encodings, lamp vectors and parameter helpers for the
// two-approach intersection controller.
package traffic_light_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_AR_TO_NS = 3'd0,
    ST_NS_G     = 3'd1,
    ST_NS_Y     = 3'd2,
    ST_AR_TO_EW = 3'd3,
    ST_EW_G     = 3'd4,
    ST_EW_Y     = 3'd5,
    ST_WALK     = 3'd6,
    ST_FLASH    = 3'd7
  } state_e;

  typedef struct packed {
    logic ns_r;
    logic ns_y;
    logic ns_g;
    logic ew_r;
    logic ew_y;
    logic ew_g;
    logic walk;
  } lamps_t;

  localparam lamps_t LAMPS_ALL_RED = 7'b100_100_0;
  localparam lamps_t LAMPS_NS_G    = 7'b001_100_0;
  localparam lamps_t LAMPS_NS_Y    = 7'b010_100_0;
  localparam lamps_t LAMPS_EW_G    = 7'b100_001_0;
  localparam lamps_t LAMPS_EW_Y    = 7'b100_010_0;
  localparam lamps_t LAMPS_WALK    = 7'b100_100_1;

  function automatic bit ticks_fit(input int ticks, input int w);
    return (ticks >= 1) && (ticks <= (1 << w));
  endfunction

  // Night mode blinks both yellows together and darkens everything else.
  function automatic lamps_t lamps_for(input state_e s, input logic flash_phase);
    lamps_t l;
    l = LAMPS_ALL_RED;
    case (s)
      ST_NS_G:  l = LAMPS_NS_G;
      ST_NS_Y:  l = LAMPS_NS_Y;
      ST_EW_G:  l = LAMPS_EW_G;
      ST_EW_Y:  l = LAMPS_EW_Y;
      ST_WALK:  l = LAMPS_WALK;
      ST_FLASH: l = '{ns_r: 1'b0, ns_y: flash_phase, ns_g: 1'b0,
                      ew_r: 1'b0, ew_y: flash_phase, ew_g: 1'b0, walk: 1'b0};
      default:  l = LAMPS_ALL_RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_phase_timer.sv
// Loadable phase down-counter; expired is combinational on the final tick
// so the owning FSM can reload in the same edge it changes state.
module traffic_light_ctrl_phase_timer #(
  parameter int                 TIMER_W   = 4,
  parameter logic [TIMER_W-1:0] RESET_VAL = '0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               tick_en_i,
  output logic               expired_o
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= RESET_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0) && tick_en_i;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-approach intersection controller with all-red clearance, latched
// pedestrian walk phase and flashing-yellow night mode; Moore outputs.
module traffic_light_ctrl
  import traffic_light_ctrl_pkg::*;
#(
  parameter int TIMER_W      = 4,
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 1,
  parameter int WALK_TICKS   = 5,
  parameter int FLASH_TICKS  = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_en_i,
  input  logic       ped_req_i,
  input  logic       flash_en_i,
  output logic       ns_red_o,
  output logic       ns_yellow_o,
  output logic       ns_green_o,
  output logic       ew_red_o,
  output logic       ew_yellow_o,
  output logic       ew_green_o,
  output logic       walk_o,
  output logic [2:0] state_out_o
);

  if (!(ticks_fit(GREEN_TICKS, TIMER_W) && ticks_fit(YELLOW_TICKS, TIMER_W) &&
        ticks_fit(ALLRED_TICKS, TIMER_W) && ticks_fit(WALK_TICKS, TIMER_W) &&
        ticks_fit(FLASH_TICKS, TIMER_W))) begin : g_bad_ticks
    $error("traffic_light_ctrl: a *_TICKS value does not fit TIMER_W");
  end

  function automatic logic [TIMER_W-1:0] load_for(input state_e s);
    case (s)
      ST_NS_G, ST_EW_G: return TIMER_W'(GREEN_TICKS - 1);
      ST_NS_Y, ST_EW_Y: return TIMER_W'(YELLOW_TICKS - 1);
      ST_WALK:          return TIMER_W'(WALK_TICKS - 1);
      ST_FLASH:         return TIMER_W'(FLASH_TICKS - 1);
      default:          return TIMER_W'(ALLRED_TICKS - 1);
    endcase
  endfunction

  state_e state_q, state_d;
  logic   ped_q, ped_d;
  logic   flash_phase_q, flash_phase_d;
  logic   expired;
  lamps_t lamps;

  traffic_light_ctrl_phase_timer #(
    .TIMER_W  (TIMER_W),
    .RESET_VAL(TIMER_W'(ALLRED_TICKS - 1))
  ) u_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (expired),
    .load_val_i(load_for(state_d)),
    .tick_en_i (tick_en_i),
    .expired_o (expired)
  );

  always_comb begin
    state_d       = state_q;
    ped_d         = ped_q | (ped_req_i && (state_q != ST_WALK));
    flash_phase_d = flash_phase_q;
    if (expired) begin
      case (state_q)
        ST_AR_TO_NS: state_d = flash_en_i ? ST_FLASH : (ped_q ? ST_WALK : ST_NS_G);
        ST_NS_G:     state_d = ST_NS_Y;
        ST_NS_Y:     state_d = ST_AR_TO_EW;
        ST_AR_TO_EW: state_d = flash_en_i ? ST_FLASH : ST_EW_G;
        ST_EW_G:     state_d = ST_EW_Y;
        ST_EW_Y:     state_d = ST_AR_TO_NS;
        ST_WALK:     state_d = ST_NS_G;
        ST_FLASH:    state_d = flash_en_i ? ST_FLASH : ST_AR_TO_NS;
        default:     state_d = ST_AR_TO_NS;
      endcase
      // Entering WALK or FLASH consumes the request, even one arriving this cycle.
      if ((state_d != state_q) && ((state_d == ST_WALK) || (state_d == ST_FLASH))) begin
        ped_d = 1'b0;
      end
      if (state_d == ST_FLASH) begin
        flash_phase_d = (state_q == ST_FLASH) ? ~flash_phase_q : 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_AR_TO_NS;
      ped_q         <= 1'b0;
      flash_phase_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      ped_q         <= ped_d;
      flash_phase_q <= flash_phase_d;
    end
  end

  assign lamps       = lamps_for(state_q, flash_phase_q);
  assign ns_red_o    = lamps.ns_r;
  assign ns_yellow_o = lamps.ns_y;
  assign ns_green_o  = lamps.ns_g;
  assign ew_red_o    = lamps.ew_r;
  assign ew_yellow_o = lamps.ew_y;
  assign ew_green_o  = lamps.ew_g;
  assign walk_o      = lamps.walk;
  assign state_out_o = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: normal cycle, pedestrian, night
// mode, sparse ticks and asynchronous reset, plus continuous safety checks.
module tb_traffic_light_ctrl;

  logic       clk;
  logic       rst_ni;
  logic       tick_en, ped_req, flash_en;
  logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk;
  logic [2:0] state_out;

  int checks = 0;
  int errors = 0;
  int inv_errs = 0;

  traffic_light_ctrl #(
    .TIMER_W     (4),
    .GREEN_TICKS (4),
    .YELLOW_TICKS(2),
    .ALLRED_TICKS(1),
    .WALK_TICKS  (3),
    .FLASH_TICKS (2)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .tick_en_i  (tick_en),
    .ped_req_i  (ped_req),
    .flash_en_i (flash_en),
    .ns_red_o   (ns_red),
    .ns_yellow_o(ns_yellow),
    .ns_green_o (ns_green),
    .ew_red_o   (ew_red),
    .ew_yellow_o(ew_yellow),
    .ew_green_o (ew_green),
    .walk_o     (walk),
    .state_out_o(state_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] lamps_of(input logic [2:0] s);
    case (s)
      3'd1:    return 7'b001_100_0;
      3'd2:    return 7'b010_100_0;
      3'd4:    return 7'b100_001_0;
      3'd5:    return 7'b100_010_0;
      3'd6:    return 7'b100_100_1;
      default: return 7'b100_100_0;
    endcase
  endfunction

  wire [6:0] lamps = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk};

  always @(negedge clk) begin
    if (($countones({ns_red, ns_yellow, ns_green}) > 1) ||
        ($countones({ew_red, ew_yellow, ew_green}) > 1) ||
        (!ns_red && !ew_red && (state_out != 3'd7)) ||
        (walk && !(ns_red && ew_red))) begin
      inv_errs++;
      if (inv_errs <= 5)
        $display("FAIL invariant at %0t: lamps=%b state=%0d", $time, lamps, state_out);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    int i;
    ok = 1'b0;
    i  = 0;
    while (!ok && (i < budget)) begin
      step();
      if (state_out == s) ok = 1'b1;
      i++;
    end
  endtask

  task automatic test_reset();
    int exp_seq[14] = '{1, 1, 1, 1, 2, 2, 3, 4, 4, 4, 4, 5, 5, 0};
    int greens = 0;
    rst_ni = 1'b0; tick_en = 1'b1; ped_req = 1'b0; flash_en = 1'b0;
    #2;
    checks++;
    if (state_out !== 3'd0 || lamps !== 7'b100_100_0) begin
      errors++;
      $display("FAIL reset_state: state=%0d lamps=%b, want 0 / 1001000", state_out, lamps);
    end
    step(); step();
    rst_ni = 1'b1;
    checks++;
    if (state_out !== 3'd0) begin
      errors++;
      $display("FAIL reset_release: state=%0d, want 0", state_out);
    end
    for (int i = 0; i < 14; i++) begin
      step();
      if (ns_green === 1'b1) greens++;
      checks++;
      if (state_out !== 3'(exp_seq[i]) || lamps !== lamps_of(3'(exp_seq[i]))) begin
        errors++;
        $display("FAIL cycle_seq[%0d]: state=%0d lamps=%b, want %0d / %b",
                 i, state_out, lamps, exp_seq[i], lamps_of(3'(exp_seq[i])));
      end
    end
    checks++;
    if (greens != 4) begin
      errors++;
      $display("FAIL ns_green_len: %0d cycles, want 4", greens);
    end
  endtask

  task automatic test_ped_pulse();
    bit ok;
    wait_state(3'd4, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ped_reach_ew_g: timeout, state=%0d", state_out); end
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    wait_state(3'd0, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ped_reach_ar: timeout, state=%0d", state_out); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (state_out !== 3'd6 || lamps !== 7'b100_100_1) begin
        errors++;
        $display("FAIL ped_walk[%0d]: state=%0d lamps=%b, want 6 / 1001001", i, state_out, lamps);
      end
    end
    step();
    checks++;
    if (state_out !== 3'd1) begin
      errors++;
      $display("FAIL ped_walk_exit: state=%0d, want 1", state_out);
    end
    wait_state(3'd0, 20, ok);
    step();
    checks++;
    if (!ok || state_out !== 3'd1) begin
      errors++;
      $display("FAIL ped_no_repeat: state=%0d ok=%0d, want 1", state_out, ok);
    end
  endtask

  task automatic test_ped_held();
    bit ok;
    ped_req = 1'b1;
    wait_state(3'd6, 30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL held_reach_walk: timeout, state=%0d", state_out); end
    wait_state(3'd1, 10, ok);
    ped_req = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL held_walk_exit: timeout, state=%0d", state_out); end
    wait_state(3'd0, 20, ok);
    step();
    checks++;
    if (!ok || state_out !== 3'd1) begin
      errors++;
      $display("FAIL held_no_rewalk: state=%0d ok=%0d, want 1", state_out, ok);
    end
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    wait_state(3'd0, 20, ok);
    step();
    checks++;
    if (!ok || state_out !== 3'd6) begin
      errors++;
      $display("FAIL held_new_req_walk: state=%0d ok=%0d, want 6", state_out, ok);
    end
    wait_state(3'd1, 10, ok);
  endtask

  task automatic test_flash();
    bit ok;
    logic y;
    flash_en = 1'b1;
    wait_state(3'd2, 10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL flash_ns_y_completes: timeout, state=%0d", state_out); end
    wait_state(3'd3, 10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL flash_ar_to_ew: timeout, state=%0d", state_out); end
    step();
    for (int k = 0; k < 6; k++) begin
      y = ((k / 2) % 2 == 0);
      checks++;
      if (state_out !== 3'd7 || lamps !== {1'b0, y, 1'b0, 1'b0, y, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL flash_blink[%0d]: state=%0d lamps=%b, want 7 / yellows=%0d",
                 k, state_out, lamps, y);
      end
      if (k < 5) step();
    end
    flash_en = 1'b0;
    step();
    checks++;
    if (state_out !== 3'd0 || lamps !== 7'b100_100_0) begin
      errors++;
      $display("FAIL flash_exit: state=%0d lamps=%b, want 0 / 1001000", state_out, lamps);
    end
    step();
    checks++;
    if (state_out !== 3'd1) begin
      errors++;
      $display("FAIL flash_exit_ns_g: state=%0d, want 1", state_out);
    end
  endtask

  task automatic test_sparse_tick();
    logic [2:0] prev;
    int greens = 1;
    tick_en = 1'b0;
    prev = state_out;
    for (int i = 1; i <= 14; i++) begin
      tick_en = (i % 3 == 0);
      step();
      if (!tick_en) begin
        checks++;
        if (state_out !== prev) begin
          errors++;
          $display("FAIL sparse_no_tick_change[%0d]: state=%0d, want %0d", i, state_out, prev);
        end
      end
      if (state_out === 3'd1) greens++;
      prev = state_out;
    end
    tick_en = 1'b1;
    checks++;
    if (greens != 12 || state_out !== 3'd2) begin
      errors++;
      $display("FAIL sparse_ns_g_len: %0d cycles state=%0d, want 12 / 2", greens, state_out);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    wait_state(3'd4, 30, ok);
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    step();
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (!ok || state_out !== 3'd0 || lamps !== 7'b100_100_0) begin
      errors++;
      $display("FAIL async_reset: state=%0d lamps=%b ok=%0d, want 0 / 1001000", state_out, lamps, ok);
    end
    step();
    rst_ni = 1'b1;
    step();
    checks++;
    if (state_out !== 3'd1 || walk !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_no_walk: state=%0d walk=%0d, want 1 / 0", state_out, walk);
    end
  endtask

  initial begin
    test_reset();
    test_ped_pulse();
    test_ped_held();
    test_flash();
    test_sparse_tick();
    test_async_reset();
    checks++;
    if (inv_errs != 0) begin
      errors++;
      $display("FAIL safety_invariants: %0d violations, want 0", inv_errs);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Parametrised two-approach intersection controller. It drives north-south (NS) and east-west (EW) signal heads, provides a timed all-red clearance between approaches and serves a latched pedestrian walk phase. It also has a flashing-yellow night mode. Phase durations are counted in tick_en pulses from the board-level prescaler, and the outputs drive LEDs directly.

Parameters:
TIMER_W, 4, phase-timer width in bits; every *_TICKS value must be in the range 1..2^TIMER_W.
GREEN_TICKS, 8, length of the NS_G and EW_G phases in ticks.
YELLOW_TICKS, 3, length of the NS_Y and EW_Y phases in ticks.
ALLRED_TICKS, 1, length of the AR_TO_NS and AR_TO_EW clearance phases in ticks.
WALK_TICKS, 5, length of the pedestrian WALK phase in ticks.
FLASH_TICKS, 2, ticks per half-period of the flashing yellow.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
tick_en  in  1  single-cycle timing strobe; all phase timing advances only on cycles where it is high.
ped_req  in  1  pedestrian request; must already be synchronised; sampled every clk.
flash_en  in  1  night-mode request, level sensitive.
ns_red, ns_yellow, ns_green  out  1 each  NS signal head.
ew_red, ew_yellow, ew_green  out  1 each  EW signal head.
walk  out  1  pedestrian walk lamp.
state_out  out  3  current state encoding, for debug.

Behaviour:
- States and encodings: AR_TO_NS=0, NS_G=1, NS_Y=2, AR_TO_EW=3, EW_G=4, EW_Y=5, WALK=6, FLASH=7.
- Moore machine: all outputs decode only from registered state, plus flash_phase in FLASH.
- Reset asserted: state=AR_TO_NS, timer=ALLRED_TICKS-1, ped_pending=0, flash_phase=1.
  - Outputs during reset: ns_red=ew_red=1, all other lamps 0, walk=0.
  - Reset mid-phase aborts the phase immediately.
- Timer rules:
  - On state entry the timer loads DUR-1, where DUR is the duration of the new state.
  - The timer decrements on cycles with tick_en=1.
  - The phase expires on a cycle where timer==0 and tick_en=1. The transition happens at that clock edge.
  - Each state therefore lasts exactly DUR ticks. tick_en held high gives DUR clk cycles.
- Transitions on expiry:
  - AR_TO_NS: if flash_en, go to FLASH; else if ped_pending, go to WALK; else go to NS_G.
  - NS_G to NS_Y; NS_Y to AR_TO_EW.
  - AR_TO_EW: if flash_en, go to FLASH; else go to EW_G.
  - EW_G to EW_Y; EW_Y to AR_TO_NS.
  - WALK to NS_G.
  - FLASH: if flash_en=0, go to AR_TO_NS (timer loads ALLRED_TICKS-1); otherwise stay in FLASH, toggle flash_phase and reload FLASH_TICKS-1.
- Lamp decode:
  - Each head is green in its own G state and yellow in its own Y state.
  - Each head is red in every other state except FLASH.
  - walk=1 only in WALK.
  - In FLASH, all reds and greens are 0, ns_yellow=ew_yellow=flash_phase, and walk=0.
- Safety invariants:
  - At most one lamp lit per head.
  - Never both heads non-red outside FLASH.
  - walk=1 implies both heads red.
- flash_en is acted on only at all-red expiry; a green or yellow phase always completes first.
- ped_pending:
  - Set on any clk with ped_req=1 while the state is not WALK.
  - Cleared on the edge entering WALK or entering FLASH. Clear wins over a simultaneous set.
  - ped_req asserted during WALK is ignored.
- flash_phase is forced to 1 on FLASH entry.
- No arithmetic wraps: the timer is never decremented below 0.

Decomposition:
- Shared header file (tlc_defs.vh) holds:
  - the state localparams;
  - the lamp-vector localparams;
  - a TIMER_W range-check macro.
- One sub-module, tlc_phase_timer, is natural. It contains:
  - a loadable down-counter with ports load, load_val[TIMER_W-1:0], tick_en, expired;
  - expired = (cnt==0) & tick_en, combinational.
- The FSM, the ped latch and the lamp decode stay in traffic_light_ctrl.

Test Plan:
Common setup: GREEN=4, YELLOW=2, ALLRED=1, WALK=3, FLASH=2, with tick_en=1 constantly unless a scenario says otherwise.
1. Reset release, no requests -> state_out sequence 0(1 cycle),1(4),2(2),3(1),4(4),5(2),0, giving a 14-cycle period. Check ns_green=1 for exactly 4 cycles per period.
2. One-cycle ped_req pulse during EW_G -> after EW_Y: AR_TO_NS(1), WALK(3) with walk=1 and both reds=1, then NS_G. The following period has no WALK.
3. ped_req held high through WALK -> ped_pending stays 0 at WALK exit; WALK is not re-entered in the next period unless ped_req is asserted again after WALK.
4. flash_en raised during NS_G -> NS_G and NS_Y complete, AR_TO_EW(1), then FLASH. Yellows are 1,1,0,0,1,1... and all reds=0. Dropping flash_en leads to AR_TO_NS at the next FLASH expiry, then NS_G.
5. tick_en pulsed every 3rd cycle -> NS_G lasts 12 clk cycles; the state never changes on a cycle with tick_en=0.
6. Reset asserted asynchronously mid EW_G with ped_pending=1 -> outputs go immediately to both red with walk=0. After release the sequence is AR_TO_NS then NS_G, with no WALK.
Every scenario also runs a continuous assertion of the safety invariants.
